// File: rtl/time_dmr_retry_pkg.sv
`default_nettype none
// ============================================================================
// Module      : time_dmr_retry_pkg
// Description : Shared types for the time-DMR retry buffer and its ID FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package time_dmr_retry_pkg;

    localparam int c_CNT_W = 8;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        INFLIGHT = 2'd1,
        QUEUED   = 2'd2
    } entry_state_e;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_NEW   = 2'd1,
        SRC_RETRY = 2'd2
    } src_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/time_dmr_retry_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : time_dmr_retry_id_fifo
// Description : Circular FIFO of 2**ID_SIZE transaction IDs awaiting re-issue.
// Revision    : 1.0 - initial release
// ============================================================================
module time_dmr_retry_id_fifo #(
    parameter int ID_SIZE = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic [ID_SIZE-1:0] push_id_i,
    input  logic               pop_i,
    output logic [ID_SIZE-1:0] head_o,
    output logic               empty_o
);
    localparam int c_DEPTH = 2 ** ID_SIZE;

    logic [ID_SIZE-1:0] r_mem [c_DEPTH];
    logic [ID_SIZE-1:0] r_wr_ptr;
    logic [ID_SIZE-1:0] r_rd_ptr;
    logic [ID_SIZE:0]   r_count;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_mem[r_wr_ptr] <= push_id_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) begin
                r_wr_ptr <= r_wr_ptr + ID_SIZE'(1);
            end
            if (pop_i) begin
                r_rd_ptr <= r_rd_ptr + ID_SIZE'(1);
            end
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + (ID_SIZE+1)'(1);
                2'b01:   r_count <= r_count - (ID_SIZE+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_o  = r_mem[r_rd_ptr];
    assign empty_o = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/time_dmr_retry_buffer.sv
`default_nettype none
// ============================================================================
// Module      : time_dmr_retry_buffer
// Description : Tags the stream with IDs, buffers in-flight items and re-issues
//               those the DMR end stage flags as mismatched.
//               Define TIME_DMR_RETRY_STATS_EN to add retry/spurious counters.
// Revision    : 1.0 - initial release
// ============================================================================
module time_dmr_retry_buffer
    import time_dmr_retry_pkg::*;
#(
    parameter type DATA_T      = logic [7:0],
    parameter int  ID_SIZE     = 4,
    parameter int  MAX_RETRIES = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  DATA_T              data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output DATA_T              data_o,
    output logic [ID_SIZE-1:0] id_o,
    output logic               valid_o,
    input  logic               ready_i,
    input  logic [ID_SIZE-1:0] fb_id_i,
    input  logic               fb_needs_retry_i,
    input  logic               fb_valid_i,
    output logic               fb_ready_o,
`ifdef TIME_DMR_RETRY_STATS_EN
    output logic [31:0]        retry_count_o,
    output logic [31:0]        spurious_fb_count_o,
`endif
    output logic               give_up_o
);
    localparam int                 c_NUM_IDS = 2 ** ID_SIZE;
    localparam logic [c_CNT_W-1:0] c_MAX     = c_CNT_W'(MAX_RETRIES);

    typedef struct packed {
        entry_state_e       state;
        DATA_T              data;
        logic [c_CNT_W-1:0] retry_cnt;
    } entry_t;

    entry_t             r_entry [c_NUM_IDS];
    logic [ID_SIZE-1:0] r_alloc_ptr;
    logic               r_lock;
    src_e               r_lock_src;
    logic               r_give_up;

    src_e               w_src;
    logic               w_fifo_empty;
    logic [ID_SIZE-1:0] w_head;
    logic               w_hs;
    logic               w_hs_new;
    logic               w_hs_retry;
    entry_t             w_fb_entry;
    logic               w_fb_act;
    logic               w_can_retry;
    logic               w_push;

    // A held handshake keeps its source so a late retry cannot swap the beat.
    always_comb begin
        w_src = SRC_NONE;
        if (r_lock) begin
            w_src = r_lock_src;
        end else if (!w_fifo_empty) begin
            w_src = SRC_RETRY;
        end else if (r_entry[r_alloc_ptr].state == FREE) begin
            w_src = SRC_NEW;
        end
    end

    always_comb begin
        valid_o = 1'b0;
        ready_o = 1'b0;
        data_o  = '0;
        id_o    = '0;
        if (!rst_i) begin
            case (w_src)
                SRC_RETRY: begin
                    data_o  = r_entry[w_head].data;
                    id_o    = w_head;
                    valid_o = 1'b1;
                end
                SRC_NEW: begin
                    data_o  = data_i;
                    id_o    = r_alloc_ptr;
                    valid_o = valid_i;
                    ready_o = ready_i;
                end
                default: ;
            endcase
        end
    end

    assign w_hs        = valid_o && ready_i;
    assign w_hs_new    = w_hs && (w_src == SRC_NEW);
    assign w_hs_retry  = w_hs && (w_src == SRC_RETRY);
    assign w_fb_entry  = r_entry[fb_id_i];
    assign w_fb_act    = fb_valid_i && (w_fb_entry.state == INFLIGHT);
    assign w_can_retry = (w_fb_entry.retry_cnt < c_MAX);
    assign w_push      = w_fb_act && fb_needs_retry_i && w_can_retry;
    assign fb_ready_o  = 1'b1;
    assign give_up_o   = r_give_up;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lock      <= 1'b0;
            r_lock_src  <= SRC_NONE;
            r_alloc_ptr <= '0;
            r_give_up   <= 1'b0;
        end else begin
            r_lock      <= valid_o && !ready_i;
            r_lock_src  <= w_src;
            r_give_up   <= w_fb_act && fb_needs_retry_i && !w_can_retry;
            if (w_hs_new) begin
                r_alloc_ptr <= r_alloc_ptr + ID_SIZE'(1);
            end
        end
    end

    // Handshake updates come last so they take precedence over feedback.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < c_NUM_IDS; i++) begin
                r_entry[i] <= '0;
            end
        end else begin
            if (w_fb_act) begin
                if (w_push) begin
                    r_entry[fb_id_i].state     <= QUEUED;
                    r_entry[fb_id_i].retry_cnt <= w_fb_entry.retry_cnt + c_CNT_W'(1);
                end else begin
                    r_entry[fb_id_i].state <= FREE;
                end
            end
            if (w_hs_new) begin
                r_entry[r_alloc_ptr] <= '{state: INFLIGHT, data: data_i, retry_cnt: '0};
            end
            if (w_hs_retry) begin
                r_entry[w_head].state <= INFLIGHT;
            end
        end
    end

    time_dmr_retry_id_fifo #(
        .ID_SIZE (ID_SIZE)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (w_push),
        .push_id_i (fb_id_i),
        .pop_i     (w_hs_retry),
        .head_o    (w_head),
        .empty_o   (w_fifo_empty)
    );

`ifdef TIME_DMR_RETRY_STATS_EN
    logic [31:0] r_retry_count;
    logic [31:0] r_spurious_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_retry_count    <= '0;
            r_spurious_count <= '0;
        end else begin
            if (w_push) begin
                r_retry_count <= sat_inc32(r_retry_count);
            end
            if (fb_valid_i && !w_fb_act) begin
                r_spurious_count <= sat_inc32(r_spurious_count);
            end
        end
    end

    assign retry_count_o       = r_retry_count;
    assign spurious_fb_count_o = r_spurious_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_time_dmr_retry_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_dmr_retry_buffer
// Description : Scoreboard bench for time_dmr_retry_buffer (directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_dmr_retry_buffer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_o;
    logic [3:0] id_o;
    logic       valid_o;
    logic       ready_i;
    logic [3:0] fb_id_i;
    logic       fb_needs_retry_i;
    logic       fb_valid_i;
    logic       fb_ready_o;
    logic       give_up_o;
`ifdef TIME_DMR_RETRY_STATS_EN
    logic [31:0] retry_count_o;
    logic [31:0] spurious_fb_count_o;
`endif

    always #5 clk_i = ~clk_i;

    time_dmr_retry_buffer #(
        .DATA_T      (logic [7:0]),
        .ID_SIZE     (4),
        .MAX_RETRIES (3)
    ) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .data_i              (data_i),
        .valid_i             (valid_i),
        .ready_o             (ready_o),
        .data_o              (data_o),
        .id_o                (id_o),
        .valid_o             (valid_o),
        .ready_i             (ready_i),
        .fb_id_i             (fb_id_i),
        .fb_needs_retry_i    (fb_needs_retry_i),
        .fb_valid_i          (fb_valid_i),
        .fb_ready_o          (fb_ready_o),
`ifdef TIME_DMR_RETRY_STATS_EN
        .retry_count_o       (retry_count_o),
        .spurious_fb_count_o (spurious_fb_count_o),
`endif
        .give_up_o           (give_up_o)
    );

    typedef struct packed {
        logic [3:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_gu     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every downstream handshake must match the oldest expectation.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (give_up_o) n_gu++;
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_issue: got id %0d data %0h, expected no issue", id_o, data_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("issue{id,data}", {20'd0, id_o, data_o}, {20'd0, mon_e.id, mon_e.data});
                end
            end
        end
    end

    task automatic expect_issue(input logic [3:0] id, input logic [7:0] d);
        exp_q.push_back('{id: id, data: d});
    endtask

    task automatic offer(input logic [7:0] d, input logic [3:0] id);
        data_i  = d;
        valid_i = 1'b1;
        expect_issue(id, d);
    endtask

    task automatic wait_new_hs();
        bit got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk_i);
            if (valid_o && ready_o) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL new_hs_timeout: got no handshake, required one within 20 cycles");
        end
        @(posedge clk_i);
        #1 valid_i = 1'b0;
    endtask

    task automatic send_new(input logic [7:0] d, input logic [3:0] id);
        offer(d, id);
        wait_new_hs();
    endtask

    task automatic wait_hs(input logic [3:0] id);
        bit got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk_i);
            if (valid_o && ready_i && id_o == id) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL hs_timeout: got no handshake for id %0d, required one within 20 cycles", id);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic fb(input logic [3:0] id, input logic retry);
        fb_id_i          = id;
        fb_needs_retry_i = retry;
        fb_valid_i       = 1'b1;
        @(posedge clk_i);
        #1 fb_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish before 200us");
        $fatal(1);
    end

    initial begin
        rst_i            = 1'b1;
        data_i           = 8'h55;
        valid_i          = 1'b1;
        ready_i          = 1'b1;
        fb_id_i          = 4'd0;
        fb_needs_retry_i = 1'b1;
        fb_valid_i       = 1'b1;
        repeat (2) @(negedge clk_i);
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_ready_o", 32'(ready_o), 32'd0);
        check("rst_give_up_o", 32'(give_up_o), 32'd0);
        check("rst_data_o", 32'(data_o), 32'd0);
        check("rst_id_o", 32'(id_o), 32'd0);
        check("rst_fb_ready_o", 32'(fb_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        rst_i      = 1'b0;
        valid_i    = 1'b0;
        fb_valid_i = 1'b0;
        @(negedge clk_i);
        check("idle_ready_o", 32'(ready_o), 32'd1);
        check("idle_valid_o", 32'(valid_o), 32'd0);
        @(posedge clk_i);
        #1;

        // Clean stream: 20 items, ids wrap 0..15,0..3.
        for (int i = 0; i < 20; i++) begin
            send_new(8'(i), 4'(i));
            @(posedge clk_i);
            #1;
            fb(4'(i), 1'b0);
        end

        // Exhaustion: alloc_ptr is 4; fill all 16 IDs without feedback.
        for (int k = 0; k < 16; k++) begin
            send_new(8'h40 + 8'(k), 4'(4 + k));
        end
        offer(8'h77, 4'd4);
        repeat (2) begin
            @(negedge clk_i);
            check("exhaust_ready_o", 32'(ready_o), 32'd0);
            check("exhaust_valid_o", 32'(valid_o), 32'd0);
        end
        @(posedge clk_i);
        #1;
        fb(4'd4, 1'b0);
        @(negedge clk_i);
        check("unstall_ready_id", {31'd0, ready_o} << 4 | 32'(id_o), 32'h14);
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k != 4) fb(4'(k), 1'b0);
        end
        fb(4'd4, 1'b0);

        // Single retry: 0xA5 gets id 5.
        send_new(8'hA5, 4'd5);
        expect_issue(4'd5, 8'hA5);
        fb(4'd5, 1'b1);
        @(negedge clk_i);
        check("retry_valid_o", 32'(valid_o), 32'd1);
        check("retry_id_o", 32'(id_o), 32'd5);
        check("retry_data_o", 32'(data_o), 32'hA5);
        check("retry_ready_o", 32'(ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        fb(4'd5, 1'b0);

        // Give up: id 6 fails four times.
        send_new(8'h3C, 4'd6);
        for (int r = 0; r < 3; r++) begin
            expect_issue(4'd6, 8'h3C);
            fb(4'd6, 1'b1);
            wait_hs(4'd6);
        end
        fb(4'd6, 1'b1);
        @(negedge clk_i);
        check("give_up_pulse", 32'(give_up_o), 32'd1);
        @(negedge clk_i);
        check("give_up_clear", 32'(give_up_o), 32'd0);
        check("give_up_no_reissue", 32'(valid_o), 32'd0);
        @(posedge clk_i);
        #1;

        // Stall stability: NEW id 8 held while retry of id 7 arrives.
        send_new(8'h11, 4'd7);
        ready_i = 1'b0;
        offer(8'h22, 4'd8);
        @(posedge clk_i);
        #1;
        expect_issue(4'd7, 8'h11);
        fb(4'd7, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            check("stall_hold{v,id,data}", {19'd0, valid_o, id_o, data_o}, {19'd0, 1'b1, 4'd8, 8'h22});
        end
        @(posedge clk_i);
        #1 ready_i = 1'b1;
        wait_hs(4'd8);
        valid_i = 1'b0;
        wait_hs(4'd7);
        fb(4'd7, 1'b0);
        fb(4'd8, 1'b0);

        // Spurious feedback: queued id 9 and free id 12.
        send_new(8'h44, 4'd9);
        ready_i = 1'b0;
        expect_issue(4'd9, 8'h44);
        fb(4'd9, 1'b1);
        fb(4'd9, 1'b1);
        fb(4'd12, 1'b0);
        @(negedge clk_i);
        check("spur_pending{v,id}", {27'd0, valid_o, id_o}, {27'd0, 1'b1, 4'd9});
        @(posedge clk_i);
        #1 ready_i = 1'b1;
        wait_hs(4'd9);
        fb(4'd9, 1'b0);
        repeat (5) @(negedge clk_i);

`ifdef TIME_DMR_RETRY_STATS_EN
        check("retry_count_o", retry_count_o, 32'd6);
        check("spurious_fb_count_o", spurious_fb_count_o, 32'd2);
`endif
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        check("give_up_pulses", 32'(n_gu), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
